int_div_arbiter: RTL
====================

Name: int_div_arbiter

Overview:
- Round-robin arbiter sharing one int_div_pipeline instance among num_req requesters (e.g. per-core ALU slots).
- Buffers one pending divide per requester and issues one operation at a time on the divider req/ack handshake.
- Routes each result back to the requester that issued it, with a one-cycle ack pulse.

Parameters:
bitwidth, 32, operand/result width; must match the divider.
num_req, 4, number of requesters, 2..16; pointer width is $clog2(num_req).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous active-low reset.
req  input  num_req  per-requester one-cycle request pulse.
a  input  num_req*bitwidth  dividends, slice i = a[i*bitwidth +: bitwidth].
b  input  num_req*bitwidth  divisors, same slicing.
ack  output  num_req  one-hot one-cycle result pulse.
quotient  output  bitwidth  result, valid only while any ack bit is 1.
remainder  output  bitwidth  result, valid only while any ack bit is 1.
busy  output  1  high when the FSM is not in IDLE.
div_req  output  1  one-cycle start pulse to the divider.
div_a  output  bitwidth  divider dividend.
div_b  output  bitwidth  divider divisor.
div_ack  input  1  divider done pulse.
div_quotient  input  bitwidth  divider result.
div_remainder  input  bitwidth  divider result.

Behaviour:
- Reset (rst=0, async): state=IDLE, pending=0, rr_ptr=0, grant=0, ack=0, div_req=0, busy=0, and div_a, div_b, quotient, remainder, operand regs = 0.
- Capture: at a posedge with req[i]=1 and pending[i]=0, set pending[i]=1 and latch a_i/b_i into per-requester operand regs.
  - req[i]=1 while pending[i]=1 is dropped silently; requester protocol forbids it.
- Round-robin select: search pending from rr_ptr upward with wrap; lowest index at or above rr_ptr wins.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any pending bit is set at a posedge, latch grant, load div_a/div_b from the granted operand regs, go to ISSUE.
  - A request captured at a posedge is selectable at the next posedge, not the same one.
  - ISSUE: div_req=1 for exactly this cycle; next state is WAIT.
  - WAIT: at a posedge with div_ack=1, latch div_quotient/div_remainder into quotient/remainder, clear pending[grant], set rr_ptr=(grant+1) mod num_req, go to RESP.
  - RESP: ack[grant]=1 for exactly one cycle with results stable; next state is IDLE.
- div_ack outside WAIT is ignored, including a late ack after reset.
- Min latency, req pulse at posedge P0 with FSM idle:
  - ISSUE during cycle P1..P2; WAIT from P2.
  - If div_ack is high at posedge Pk, RESP/ack is high during Pk..Pk+1.
  - Back-to-back grants are separated by one IDLE cycle.
- quotient/remainder hold their last value outside RESP; verification must check them only when ack is high.
- A req[grant] pulse during RESP is captured (pending already cleared) and competes normally.
- Reset mid-operation aborts the in-flight divide and all pending requests; nothing is acked.
- No arithmetic is done in this block; values pass through unmodified at bitwidth.

Optional Feature:
- Macro: INT_DIV_ARB_DIV0_BYPASS_EN.
- Defined: if the granted divisor is 0, IDLE goes directly to RESP without driving div_req. Result is quotient = all ones ({bitwidth{1'b1}}) and remainder = dividend (RISC-V semantics). rr_ptr and pending update as in WAIT.
- Undefined: divide-by-zero is forwarded to the divider like any other operation; the result is whatever the divider returns.

Test Plan:
- Single op: requester 1 pulses req with a=11, b=3 → div_req one cycle later with div_a=11, div_b=3; after div_ack, ack=4'b0010 for one cycle with quotient=3, remainder=2.
- Contention: requesters 0 and 2 pulse in the same cycle (7/2 and 7/3) after reset → requester 0 acked first (3,1), then requester 2 (2,1); exactly two div_req pulses; busy drops after the second RESP.
- Fairness: all four request continuously (re-pulse after each ack) → grant order 0,1,2,3,0,…; no requester is skipped.
- Robustness: div_ack pulsed while in IDLE, and duplicate req[i] while pending[i]=1 → no ack, no state change, one divide only.
- Reset: rst=0 asserted during WAIT with 123153/2424 in flight → all outputs zero immediately; a subsequent div_ack is ignored; a new op 123153/2424 then returns 50, 1953.
- Div-by-zero with INT_DIV_ARB_DIV0_BYPASS_EN: a=5, b=0 → no div_req; ack within 2 cycles; quotient=32'hFFFFFFFF, remainder=5. Without the macro, div_req issues with div_b=0.

Source files
------------

// File: rtl/int_div_arbiter.sv
// int_div_arbiter
// Round-robin arbiter that shares a single int_div_pipeline among num_req
// requesters. Each requester may have one divide pending. Operations are
// issued one at a time on the divider req/ack handshake, and each result is
// routed back to its requester with a one-cycle ack pulse.
//
// Optional feature, controlled by the macro INT_DIV_ARB_DIV0_BYPASS_EN:
//   When the macro is defined, a granted divide whose divisor is zero never
//   reaches the divider. It completes locally with quotient = all ones and
//   remainder = dividend. When the macro is undefined, a zero divisor is
//   forwarded to the divider like any other operand.
//
// Handshake semantics (requester side and divider side):
//   req[i]   is a one-cycle pulse. It is accepted only while requester i has
//            nothing pending. A pulse while a request is pending is dropped.
//   ack[i]   is a one-cycle pulse. quotient/remainder are valid only while
//            some ack bit is high.
//   div_req  is a one-cycle start pulse. div_a/div_b are held stable from that
//            pulse until the matching div_ack.
//   div_ack  is accepted only in WAIT. Outside WAIT it is ignored, which also
//            covers a stale ack that arrives after a reset.
module int_div_arbiter #(
    parameter int bitwidth = 32,
    parameter int num_req  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [num_req-1:0]           req,
    input  logic [num_req*bitwidth-1:0]  a,
    input  logic [num_req*bitwidth-1:0]  b,
    output logic [num_req-1:0]           ack,
    output logic [bitwidth-1:0]          quotient,
    output logic [bitwidth-1:0]          remainder,
    output logic                         busy,
    output logic                         div_req,
    output logic [bitwidth-1:0]          div_a,
    output logic [bitwidth-1:0]          div_b,
    input  logic                         div_ack,
    input  logic [bitwidth-1:0]          div_quotient,
    input  logic [bitwidth-1:0]          div_remainder,
    output logic [1:0]                   state_dbg
);

    localparam int ptr_w = $clog2(num_req);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [num_req-1:0]  pending;
    logic [bitwidth-1:0] op_a [num_req];
    logic [bitwidth-1:0] op_b [num_req];
    logic [ptr_w-1:0]    rr_ptr;
    logic [ptr_w-1:0]    grant;
    logic [ptr_w-1:0]    sel;
    logic                any_pending;
    logic                take;        // IDLE accepts the selected request
    logic                bypass_take; // accepted request completes without the divider
    logic                done;        // current operation completes at this edge
    logic [ptr_w-1:0]    done_idx;    // requester whose pending bit is cleared

    // Wrap-around increment of a requester pointer.
    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        if (int'(p) == num_req - 1) begin
            return '0;
        end
        return p + ptr_w'(1);
    endfunction

    assign any_pending = |pending;
    assign state_dbg   = state;

    // Round-robin pick: first pending requester at or above rr_ptr, with wrap.
    always_comb begin
        int   idx;
        logic found;
        sel   = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < num_req; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (!found && pending[ptr_w'(idx)]) begin
                found = 1'b1;
                sel   = ptr_w'(idx);
            end
        end
    end

    // Decide whether the picked request skips the divider.
    always_comb begin
        take = (state == IDLE) && any_pending;
`ifdef INT_DIV_ARB_DIV0_BYPASS_EN
        bypass_take = take && (op_b[sel] == '0);
`else
        bypass_take = 1'b0;
`endif
        done     = bypass_take || ((state == WAIT) && div_ack);
        done_idx = (state == IDLE) ? sel : grant;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and the pulse outputs derived from the current state.
    always_comb begin
        state_next = state;
        div_req    = 1'b0;
        ack        = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (take) begin
                    state_next = bypass_take ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_req    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (div_ack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                ack[grant] = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture into per-requester operand slots; completion frees the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            for (int i = 0; i < num_req; i++) begin
                op_a[i] <= '0;
                op_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_req; i++) begin
                if (req[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    op_a[i]    <= a[i*bitwidth +: bitwidth];
                    op_b[i]    <= b[i*bitwidth +: bitwidth];
                end
            end
            // A set above only happens when the bit is clear, and a clear here
            // only targets a bit that is set, so the two never collide.
            if (done) begin
                pending[done_idx] <= 1'b0;
            end
        end
    end

    // Grant, divider operands, results and the round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= '0;
            rr_ptr    <= '0;
            div_a     <= '0;
            div_b     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (take) begin
                grant <= sel;
                div_a <= op_a[sel];
                div_b <= op_b[sel];
            end
            if (bypass_take) begin
                quotient  <= '1;
                remainder <= op_a[sel];
                rr_ptr    <= ptr_inc(sel);
            end else if ((state == WAIT) && div_ack) begin
                quotient  <= div_quotient;
                remainder <= div_remainder;
                rr_ptr    <= ptr_inc(grant);
            end
        end
    end

endmodule
